jk_mod_counter: RTL and testbench

Parametrised synchronous modulo counter whose state is held in a bank of single-bit JK flip-flops. Each bit's next state is set only by its J/K inputs. Supports hold, count up, count down and parallel load, with wrap-around at a programmable modulus, a terminal-count flag and a sticky overflow flag. It is the multi-bit, mode-capable successor to the team's single JK master-slave flip-flop, intended as the standard counter primitive for sequencing and timing blocks.

---
 rtl/jk_pkg.sv | 14 +
 rtl/jk_mod_counter_if.sv | 24 ++
 rtl/jk_ff.sv | 29 ++
 rtl/jk_mod_counter.sv | 88 ++++++++
 tb/tb_jk_mod_counter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK-flip-flop modulo counter: operation modes and
// the elaboration-time parameter legality check.
package jk_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic bit params_legal(int width, int modulo);
    return (width >= 2) && (width <= 16) && (modulo >= 2) && (modulo <= (1 << width));
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and status bundle of the modulo counter; the master drives controls,
// the slave (counter) drives the count and flags.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             ovf;

  modport master (
    output en, mode, load_val, clr_ovf,
    input  q, qbar, tc, ovf
  );

  modport slave (
    input  en, mode, load_val, clr_ovf,
    output q, qbar, tc, ovf
  );
endinterface

// File: rtl/jk_ff.sv
// Single-bit JK flip-flop with synchronous active-high reset.
// JK = 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Qbar
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

  assign Qbar = ~Q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo counter built from a bank of JK flip-flops: hold, up, down and clamped
// parallel load, with combinational terminal count and a sticky wrap flag.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic              clk,
  input  logic              rst,
  jk_mod_counter_if.slave   bus
);

  if (!params_legal(WIDTH, MODULO)) begin : g_param_check
    $error("jk_mod_counter: illegal WIDTH=%0d / MODULO=%0d", WIDTH, MODULO);
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             wrap;
  logic             ovf;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    next_q = q;
    wrap   = 1'b0;
    j      = '0;
    k      = '0;
    if (bus.en) begin
      case (bus.mode)
        MODE_UP: begin
          wrap   = (q == MAX_Q);
          next_q = wrap ? '0 : q + WIDTH'(1);
          j      = next_q ^ q;
          k      = next_q ^ q;
        end
        MODE_DOWN: begin
          wrap   = (q == '0);
          next_q = wrap ? MAX_Q : q - WIDTH'(1);
          j      = next_q ^ q;
          k      = next_q ^ q;
        end
        MODE_LOAD: begin
          // Out-of-range loads clamp so q never leaves 0..MODULO-1.
          next_q = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
          j      = next_q;
          k      = ~next_q;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .clk  (clk),
      .rst  (rst),
      .J    (j[i]),
      .K    (k[i]),
      .Q    (q[i]),
      .Qbar (qbar[i])
    );
  end

  // A wrap on the same edge as clr_ovf wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wrap) begin
      ovf <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  assign bus.q    = q;
  assign bus.qbar = qbar;
  assign bus.ovf  = ovf;
  assign bus.tc   = bus.en && (((bus.mode == MODE_UP) && (q == MAX_Q)) ||
                               ((bus.mode == MODE_DOWN) && (q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULO=10): directed
// scenarios plus randomized traffic against a modular-arithmetic model.
module tb_jk_mod_counter;
  import jk_pkg::*;

  localparam int WIDTH  = 4;
  localparam int MODULO = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jk_mod_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_mod_counter #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_q   = 0;
  bit m_ovf = 1'b0;

  // Apply inputs on the falling edge, well away from the sampling edge.
  task automatic drive(input bit r, input bit e, input logic [1:0] m,
                       input logic [3:0] lv, input bit c);
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.mode     = m;
    bus.load_val = lv;
    bus.clr_ovf  = c;
    #1;
  endtask

  // Advance one rising edge, updating the reference model from the spec rules.
  task automatic tick();
    int nxt;
    bit wrapped;
    @(posedge clk);
    wrapped = 1'b0;
    nxt     = m_q;
    if (rst) begin
      m_q   = 0;
      m_ovf = 1'b0;
    end else begin
      if (bus.en) begin
        case (bus.mode)
          2'b01: begin
            nxt = m_q + 1;
            if (nxt == MODULO) begin nxt = 0; wrapped = 1'b1; end
          end
          2'b10: begin
            nxt = m_q - 1;
            if (nxt < 0) begin nxt = MODULO - 1; wrapped = 1'b1; end
          end
          2'b11: nxt = (int'(bus.load_val) < MODULO) ? int'(bus.load_val) : MODULO - 1;
          default: ;
        endcase
      end
      m_q = nxt;
      if (wrapped) m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
    end
    #1;
  endtask

  function automatic logic exp_tc();
    return bus.en && ((bus.mode == 2'b01 && m_q == MODULO - 1) ||
                      (bus.mode == 2'b10 && m_q == 0));
  endfunction

  task automatic test_reset();
    drive(1, 1, MODE_UP, 4'h0, 0);
    tick();
    tick();
    drive(0, 0, MODE_HOLD, 4'h0, 0);
    total++; if (bus.q !== 4'd0) begin bad++; $display("FAIL reset_q got=%0h exp=0", bus.q); end
    total++; if (bus.qbar !== 4'hF) begin bad++; $display("FAIL reset_qbar got=%0h exp=f", bus.qbar); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
    total++; if (bus.tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%0b exp=0", bus.tc); end
  endtask

  task automatic test_up_wrap();
    drive(0, 1, MODE_UP, 4'h0, 0);
    for (int i = 0; i < 9; i++) tick();
    total++; if (bus.q !== 4'd9) begin bad++; $display("FAIL up_q9 got=%0d exp=9", bus.q); end
    total++; if (bus.tc !== 1'b1) begin bad++; $display("FAIL up_tc got=%0b exp=1", bus.tc); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL up_ovf_pre got=%0b exp=0", bus.ovf); end
    tick();
    total++; if (bus.q !== 4'd0) begin bad++; $display("FAIL up_wrap_q got=%0d exp=0", bus.q); end
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL up_wrap_ovf got=%0b exp=1", bus.ovf); end
    total++; if (bus.tc !== 1'b0) begin bad++; $display("FAIL up_wrap_tc got=%0b exp=0", bus.tc); end
  endtask

  task automatic test_down_set_wins();
    drive(0, 1, MODE_HOLD, 4'h0, 1);
    tick();
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%0b exp=0", bus.ovf); end
    drive(0, 1, MODE_LOAD, 4'h0, 0);
    tick();
    drive(0, 1, MODE_DOWN, 4'h0, 1);
    total++; if (bus.tc !== 1'b1) begin bad++; $display("FAIL down_tc got=%0b exp=1", bus.tc); end
    tick();
    total++; if (bus.q !== 4'd9) begin bad++; $display("FAIL down_wrap_q got=%0d exp=9", bus.q); end
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL set_wins_ovf got=%0b exp=1", bus.ovf); end
    drive(0, 1, MODE_HOLD, 4'h0, 1);
    tick();
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL clr_after_ovf got=%0b exp=0", bus.ovf); end
    total++; if (bus.q !== 4'd9) begin bad++; $display("FAIL hold_q got=%0d exp=9", bus.q); end
  endtask

  task automatic test_load_clamp();
    drive(0, 1, MODE_UP, 4'h0, 0);
    tick();
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL pre_load_ovf got=%0b exp=1", bus.ovf); end
    drive(0, 1, MODE_LOAD, 4'd7, 0);
    tick();
    total++; if (bus.q !== 4'd7) begin bad++; $display("FAIL load7_q got=%0d exp=7", bus.q); end
    total++; if (bus.qbar !== 4'h8) begin bad++; $display("FAIL load7_qbar got=%0h exp=8", bus.qbar); end
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL load7_ovf got=%0b exp=1", bus.ovf); end
    total++; if (bus.tc !== 1'b0) begin bad++; $display("FAIL load_tc got=%0b exp=0", bus.tc); end
    drive(0, 1, MODE_LOAD, 4'd12, 0);
    tick();
    total++; if (bus.q !== 4'd9) begin bad++; $display("FAIL load12_q got=%0d exp=9", bus.q); end
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL load12_ovf got=%0b exp=1", bus.ovf); end
    drive(0, 1, MODE_LOAD, 4'd10, 0);
    tick();
    total++; if (bus.q !== 4'd9) begin bad++; $display("FAIL load10_q got=%0d exp=9", bus.q); end
    drive(0, 1, MODE_LOAD, 4'd0, 0);
    tick();
    total++; if (bus.q !== 4'd0) begin bad++; $display("FAIL load0_q got=%0d exp=0", bus.q); end
  endtask

  task automatic test_hold_enable();
    drive(0, 1, MODE_LOAD, 4'd4, 0);
    tick();
    drive(0, 0, MODE_UP, 4'd0, 0);
    for (int i = 0; i < 5; i++) tick();
    total++; if (bus.q !== 4'd4) begin bad++; $display("FAIL en0_q got=%0d exp=4", bus.q); end
    total++; if (bus.tc !== 1'b0) begin bad++; $display("FAIL en0_tc got=%0b exp=0", bus.tc); end
    drive(0, 1, MODE_HOLD, 4'd0, 0);
    for (int i = 0; i < 3; i++) tick();
    total++; if (bus.q !== 4'd4) begin bad++; $display("FAIL hold_q4 got=%0d exp=4", bus.q); end
    drive(0, 1, MODE_LOAD, 4'd9, 0);
    tick();
    drive(0, 0, MODE_UP, 4'd0, 0);
    total++; if (bus.tc !== 1'b0) begin bad++; $display("FAIL en0_tc_at_max got=%0b exp=0", bus.tc); end
    drive(0, 0, MODE_UP, 4'd0, 1);
    tick();
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL en0_clr_ovf got=%0b exp=0", bus.ovf); end
    total++; if (bus.q !== 4'd9) begin bad++; $display("FAIL en0_clr_q got=%0d exp=9", bus.q); end
  endtask

  task automatic test_reset_mid_op();
    drive(0, 1, MODE_UP, 4'd0, 0);
    tick();
    drive(0, 1, MODE_LOAD, 4'd5, 0);
    tick();
    total++; if (bus.q !== 4'd5 || bus.ovf !== 1'b1) begin
      bad++; $display("FAIL mid_setup q=%0d ovf=%0b exp q=5 ovf=1", bus.q, bus.ovf);
    end
    drive(1, 1, MODE_LOAD, 4'd3, 0);
    tick();
    total++; if (bus.q !== 4'd0) begin bad++; $display("FAIL mid_rst_q got=%0d exp=0", bus.q); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%0b exp=0", bus.ovf); end
    drive(0, 1, MODE_DOWN, 4'd0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.q !== ~bus.qbar) begin
        bad++; $display("FAIL mid_compl q=%0h qbar=%0h exp qbar=%0h", bus.q, bus.qbar, ~bus.q);
      end
    end
  endtask

  task automatic test_random();
    bit       r, e, c;
    logic [1:0] m;
    logic [3:0] lv;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = 2'($urandom_range(0, 3));
      lv = 4'($urandom_range(0, 15));
      c  = ($urandom_range(0, 7) == 0);
      drive(r, e, m, lv, c);
      total++; if (bus.tc !== exp_tc()) begin
        bad++; $display("FAIL rnd_tc cyc=%0d got=%0b exp=%0b", i, bus.tc, exp_tc());
      end
      tick();
      total++; if (bus.q !== 4'(m_q)) begin
        bad++; $display("FAIL rnd_q cyc=%0d got=%0d exp=%0d", i, bus.q, m_q);
      end
      total++; if (bus.qbar !== ~4'(m_q)) begin
        bad++; $display("FAIL rnd_qbar cyc=%0d got=%0h exp=%0h", i, bus.qbar, ~4'(m_q));
      end
      total++; if (bus.ovf !== m_ovf) begin
        bad++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", i, bus.ovf, m_ovf);
      end
    end
  endtask

  initial begin
    bus.en       = 1'b0;
    bus.mode     = MODE_HOLD;
    bus.load_val = '0;
    bus.clr_ovf  = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_set_wins();
    test_load_clamp();
    test_hold_enable();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
